uart_tx_arb: RTL and testbench

UART_TX_ARB -- requirements
Module: uart_tx_arb

---
 rtl/uart_tx_arb.sv | 130 +++++++++++++
 tb/tb_uart_tx_arb.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arb.sv
// Purpose: arbitrates two word requesters onto one byte-wide UART transmitter, LSB byte first.
// Latency: accept edge -> tx_start in the next cycle; tx_busy seen low -> next byte's tx_start one edge later.
// Backpressure: readies only in IDLE with tx_busy low; an accepted word is always sent in full.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   reqN_valid/_data/_len     request handshake, 32-bit payload, byte count minus 1
//   reqN_ready                combinational grant (IDLE, transmitter idle, requester granted)
//   tx_start, sdata           one-cycle registered start pulse and the byte that goes with it
//   tx_busy                   transmitter busy flag
//   arb_busy                  high whenever a word is in flight
// Build option: define UART_TX_ARB_PRIO_EN for fixed priority (req0 over req1);
// otherwise requesters are served round-robin.
module uart_tx_arb (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [31:0] req0_data,
  input  logic [1:0]  req0_len,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [31:0] req1_data,
  input  logic [1:0]  req1_len,
  output logic        req1_ready,
  output logic        tx_start,
  output logic [7:0]  sdata,
  input  logic        tx_busy,
  output logic        arb_busy
);

  typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_t;

  state_t      state, state_nxt;
  logic [31:0] shift_buf;
  logic [31:0] buf_nxt;
  logic [1:0]  remaining;
  logic        grant1;     // 1: req1 wins the current arbitration
  logic        load;       // accept a new word this cycle
  logic        shift;      // advance to the next byte of the current word
  logic [31:0] sel_data;
  logic [1:0]  sel_len;

`ifdef UART_TX_ARB_PRIO_EN
  assign grant1 = req1_valid & ~req0_valid;
`else
  logic last1;             // 1: req1 was the last requester accepted
  // On a tie the requester not served last wins.
  assign grant1 = req1_valid & (~req0_valid | ~last1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last1 <= 1'b1;       // req0 wins the first tie after reset
    end else if (load) begin
      last1 <= grant1;
    end
  end
`endif

  assign sel_data = grant1 ? req1_data : req0_data;
  assign sel_len  = grant1 ? req1_len  : req0_len;
  assign arb_busy = (state != IDLE);

  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    load       = 1'b0;
    shift      = 1'b0;
    case (state)
      IDLE: begin
        if (!tx_busy) begin
          req0_ready = req0_valid & ~grant1;
          req1_ready = grant1;
          if (req0_valid | req1_valid) begin
            load      = 1'b1;
            state_nxt = START;
          end
        end
      end
      START: begin
        state_nxt = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_nxt = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          if (remaining == 2'd0) begin
            state_nxt = IDLE;
          end else begin
            shift     = 1'b1;
            state_nxt = START;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // sdata is loaded from the buffer's next value, so during START it equals buf[7:0].
  assign buf_nxt = load ? sel_data : (shift_buf >> 8);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      shift_buf <= 32'h0;
      remaining <= 2'd0;
      tx_start  <= 1'b0;
      sdata     <= 8'h00;
    end else begin
      state    <= state_nxt;
      // Only IDLE and WAIT_DONE lead into START, so the pulse can never repeat back to back.
      tx_start <= load | shift;
      if (load) begin
        shift_buf <= buf_nxt;
        remaining <= sel_len;
        sdata     <= buf_nxt[7:0];
      end else if (shift) begin
        shift_buf <= buf_nxt;
        remaining <= remaining - 2'd1;
        sdata     <= buf_nxt[7:0];
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
module tb_uart_tx_arb;

  logic        clk;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic [31:0] req0_data, req1_data;
  logic [1:0]  req0_len, req1_len;
  logic        req0_ready, req1_ready;
  logic        tx_start;
  logic [7:0]  sdata;
  logic        tx_busy;
  logic        arb_busy;

  uart_tx_arb dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_len   (req0_len),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_len   (req1_len),
    .req1_ready (req1_ready),
    .tx_start   (tx_start),
    .sdata      (sdata),
    .tx_busy    (tx_busy),
    .arb_busy   (arb_busy)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] got_q[$];   // every byte launched with tx_start
  logic [7:0] exp_q[$];   // bytes owed for words seen accepted
  bit         last1_m;    // reference: last requester served was req1
  bit         ext_busy;
  bit         rand_busy;
  int         busy_len;

  typedef struct {
    bit          sel;
    logic [31:0] data;
    logic [1:0]  len;
    int          busy;
    int          exp_n;
    logic [31:0] exp_bytes;   // expected bytes, first sent in [7:0]
  } vec_t;

  vec_t vecs[6];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  // Transmitter model: busy for a given number of cycles starting the cycle after tx_start.
  initial begin
    int cnt;
    logic busy_r;
    cnt = 0;
    tx_busy = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (cnt != 0) begin
        busy_r = 1'b1;
        cnt--;
      end else begin
        busy_r = 1'b0;
      end
      if (tx_start) cnt = rand_busy ? $urandom_range(1, 4) : busy_len;
      tx_busy = busy_r | ext_busy;
    end
  end

  // Scoreboard and protocol checks, sampled mid-cycle.
  initial begin
    bit          prev_start, prev_rst, win, exp_win;
    logic [7:0]  prev_sdata;
    logic [31:0] wd;
    logic [1:0]  wl;
    prev_start = 1'b0;
    prev_rst   = 1'b1;
    prev_sdata = 8'h00;
    forever begin
      @(negedge clk);
      if (tx_start) begin
        got_q.push_back(sdata);
        chk("tx_start back to back", {31'b0, prev_start}, 32'd0);
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL byte stream: got unexpected byte %h, required none", sdata);
        end else begin
          chk("byte stream", {24'b0, sdata}, {24'b0, exp_q.pop_front()});
        end
      end else if (!rst && !prev_rst) begin
        chk("sdata hold", {24'b0, sdata}, {24'b0, prev_sdata});
      end
      if (rst) begin
        exp_q.delete();
        last1_m = 1'b1;
      end else begin
        chk("ready exclusive", {31'b0, req0_ready & req1_ready}, 32'd0);
        if (arb_busy || tx_busy) chk("ready while busy", {30'b0, req0_ready, req1_ready}, 32'd0);
        if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
          win = req1_ready;
          if (req0_valid && req1_valid) begin
`ifdef UART_TX_ARB_PRIO_EN
            exp_win = 1'b0;
`else
            exp_win = ~last1_m;
`endif
            chk("arbitration", {31'b0, win}, {31'b0, exp_win});
          end
          last1_m = win;
          wd = win ? req1_data : req0_data;
          wl = win ? req1_len : req0_len;
          for (int i = 0; i <= int'(wl); i++) exp_q.push_back(wd[8*i +: 8]);
        end
      end
      prev_start = tx_start;
      prev_rst   = rst;
      prev_sdata = sdata;
    end
  end

  task automatic set_req(input bit sel, input bit v, input logic [31:0] d, input logic [1:0] l);
    if (!sel) begin
      req0_valid = v; req0_data = d; req0_len = l;
    end else begin
      req1_valid = v; req1_data = d; req1_len = l;
    end
  endtask

  task automatic drop_req(input bit sel);
    if (!sel) req0_valid = 1'b0;
    else req1_valid = 1'b0;
  endtask

  // Present one word, wait for its handshake, then check the start pulse follows at once.
  task automatic send(input bit sel, input logic [31:0] d, input logic [1:0] l);
    int t;
    bit ok;
    t = 0;
    ok = 1'b0;
    @(posedge clk); #1;
    set_req(sel, 1'b1, d, l);
    while (t < 500) begin
      @(negedge clk);
      if (sel ? req1_ready : req0_ready) begin
        ok = 1'b1;
        break;
      end
      t++;
    end
    @(posedge clk); #1;
    drop_req(sel);
    if (!ok) begin
      n_vec++; n_err++;
      $display("FAIL accept timeout: got no ready, required handshake");
    end else begin
      @(negedge clk);
      chk("start latency", {31'b0, tx_start}, 32'd1);
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    @(negedge clk);
    while (arb_busy && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("arb_busy falls", {31'b0, arb_busy}, 32'd0);
    chk("idle after busy drop", {31'b0, tx_busy}, 32'd0);
  endtask

  task automatic rand_req(input bit sel, input int nwords);
    int t;
    bit done;
    for (int k = 0; k < nwords; k++) begin
      t = 0;
      done = 1'b0;
      repeat ($urandom_range(1, 4)) @(posedge clk);
      #1;
      set_req(sel, 1'b1, $urandom, 2'($urandom_range(0, 3)));
      while (!done && t < 3000) begin
        @(negedge clk);
        t++;
        if (sel ? req1_ready : req0_ready) begin
          done = 1'b1;
          @(posedge clk); #1;
          drop_req(sel);
        end else if ($urandom_range(0, 15) == 0) begin
          // withdraw for a cycle, then offer a different word
          @(posedge clk); #1;
          drop_req(sel);
          @(posedge clk); #1;
          set_req(sel, 1'b1, $urandom, 2'($urandom_range(0, 3)));
        end
      end
      if (!done) begin
        n_vec++; n_err++;
        $display("FAIL random accept timeout: got no ready, required handshake");
        drop_req(sel);
      end
    end
  endtask

  initial begin
    int t;
    logic [31:0] seq;
    vecs[0] = '{sel: 1'b0, data: 32'h44332211, len: 2'd3, busy: 20, exp_n: 4, exp_bytes: 32'h44332211};
    vecs[1] = '{sel: 1'b1, data: 32'hAABBCCDD, len: 2'd0, busy: 3,  exp_n: 1, exp_bytes: 32'h000000DD};
    vecs[2] = '{sel: 1'b0, data: 32'hCAFEF00D, len: 2'd1, busy: 1,  exp_n: 2, exp_bytes: 32'h0000F00D};
    vecs[3] = '{sel: 1'b1, data: 32'h12345678, len: 2'd2, busy: 5,  exp_n: 3, exp_bytes: 32'h00345678};
    vecs[4] = '{sel: 1'b1, data: 32'h00000000, len: 2'd3, busy: 2,  exp_n: 4, exp_bytes: 32'h00000000};
    vecs[5] = '{sel: 1'b0, data: 32'hFF00FF00, len: 2'd2, busy: 1,  exp_n: 3, exp_bytes: 32'h0000FF00};

    rst = 1'b1;
    req0_valid = 1'b0; req0_data = '0; req0_len = '0;
    req1_valid = 1'b0; req1_data = '0; req1_len = '0;
    ext_busy = 1'b0;
    rand_busy = 1'b0;
    busy_len = 3;
    last1_m = 1'b1;

    // reset state
    repeat (2) @(negedge clk);
    chk("reset tx_start", {31'b0, tx_start}, 32'd0);
    chk("reset sdata", {24'b0, sdata}, 32'd0);
    chk("reset arb_busy", {31'b0, arb_busy}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // single words from the table
    for (int v = 0; v < 6; v++) begin
      busy_len = vecs[v].busy;
      got_q.delete();
      send(vecs[v].sel, vecs[v].data, vecs[v].len);
      wait_idle();
      chk("pulse count", got_q.size(), vecs[v].exp_n);
      for (int i = 0; i < vecs[v].exp_n; i++) begin
        if (i < got_q.size()) chk("table byte", {24'b0, got_q[i]}, {24'b0, vecs[v].exp_bytes[8*i +: 8]});
      end
    end

    // inter-byte timing: next start in the second cycle that tx_busy reads low
    busy_len = 3;
    got_q.delete();
    send(1'b0, 32'h0000BEEF, 2'd1);
    t = 0;
    while (!tx_busy && t < 50) begin @(negedge clk); t++; end
    while (tx_busy && t < 100) begin @(negedge clk); t++; end
    chk("gap first low cycle", {31'b0, tx_start}, 32'd0);
    @(negedge clk);
    chk("gap second low cycle", {31'b0, tx_start}, 32'd1);
    chk("gap byte", {24'b0, sdata}, 32'h000000BE);
    wait_idle();

    // transmitter held busy while idle blocks acceptance
    @(posedge clk); #1;
    ext_busy = 1'b1;
    set_req(1'b0, 1'b1, 32'h00000077, 2'd0);
    repeat (4) begin
      @(negedge clk);
      chk("ready held off", {31'b0, req0_ready}, 32'd0);
    end
    @(posedge clk); #1;
    ext_busy = 1'b0;
    @(negedge clk);
    chk("ready after busy drop", {31'b0, req0_ready}, 32'd1);
    @(posedge clk); #1;
    drop_req(1'b0);
    @(negedge clk);
    chk("held-off start", {31'b0, tx_start}, 32'd1);
    chk("held-off byte", {24'b0, sdata}, 32'h00000077);
    wait_idle();

    // both requesters valid continuously, fresh from reset
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    busy_len = 2;
    got_q.delete();
    set_req(1'b0, 1'b1, 32'h00000001, 2'd0);
    set_req(1'b1, 1'b1, 32'h00000002, 2'd0);
    t = 0;
    while (got_q.size() < 4 && t < 400) begin @(negedge clk); t++; end
    @(posedge clk); #1;
    drop_req(1'b0);
    drop_req(1'b1);
    wait_idle();
`ifdef UART_TX_ARB_PRIO_EN
    seq = 32'h00010101;
    for (int i = 0; i < 3; i++)
`else
    seq = 32'h02010201;
    for (int i = 0; i < 4; i++)
`endif
    begin
      if (i < got_q.size()) chk("contention order", {24'b0, got_q[i]}, {24'b0, seq[8*i +: 8]});
      else chk("contention count", got_q.size(), i + 1);
    end

    // reset during the second byte of a 4-byte word
    busy_len = 20;
    got_q.delete();
    send(1'b0, 32'h44332211, 2'd3);
    t = 0;
    while (got_q.size() < 2 && t < 200) begin @(negedge clk); t++; end
    repeat (5) @(negedge clk);
    chk("mid-word busy", {31'b0, arb_busy}, 32'd1);
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    chk("abort tx_start", {31'b0, tx_start}, 32'd0);
    chk("abort sdata", {24'b0, sdata}, 32'd0);
    chk("abort arb_busy", {31'b0, arb_busy}, 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("no bytes after abort", got_q.size(), 32'd2);
    chk("idle after abort", {31'b0, arb_busy}, 32'd0);
    busy_len = 2;
    got_q.delete();
    send(1'b0, 32'hA3A2A1A0, 2'd1);
    wait_idle();
    chk("post-abort count", got_q.size(), 32'd2);
    if (got_q.size() == 2) begin
      chk("post-abort byte 0", {24'b0, got_q[0]}, 32'h000000A0);
      chk("post-abort byte 1", {24'b0, got_q[1]}, 32'h000000A1);
    end

    // randomized traffic against the scoreboard
    rand_busy = 1'b1;
    fork
      rand_req(1'b0, 25);
      rand_req(1'b1, 25);
    join
    wait_idle();
    repeat (3) @(negedge clk);
    chk("scoreboard drained", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
